button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions the raw front-panel push button for the LED counter logic. Synchronizes the asynchronous button input, rejects contact bounce with a stable-sample counter, and produces a clean level plus single-cycle press, release and long-press pulses. An 8-bit press tally is also provided so that press events can drive `Led` directly. The block sits between the board pin and any logic that consumes `button`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive identical synchronized samples required to accept a transition (10 ms at 50 MHz). Must be ≥ 2.
- `LONG_CYCLES`, default 50000000: cycles after the press is accepted before `btn_long` fires. Must be > `DEBOUNCE_CYCLES`.
- Counter widths are derived from the parameters via `$clog2`.
- `clk` input 1: single system clock; everything is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `button` input 1: raw pad signal, asynchronous, active-high, bouncy.
- `btn_level` output 1: debounced button level.
- `btn_press` output 1: one-cycle pulse when a press is accepted.
- `btn_release` output 1: one-cycle pulse when a release is accepted.
- `btn_long` output 1: one-cycle pulse, at most once per press.
- `press_count` output 8: number of accepted presses, modulo 256.

## Operation
- Synchronizer: two flops, `button` → `s1` → `s2`. Both flops reset to 0. Only `s2` is used downstream.
- States:
  - IDLE: released and stable.
  - PRESS_WAIT: qualifying a press.
  - HELD: pressed and stable.
  - REL_WAIT: qualifying a release.
- State and counter rules:
  - The stable counter `dcnt` clears on every state change.
  - IDLE, `s2` = 1: go to PRESS_WAIT with `dcnt` = 1.
  - PRESS_WAIT, `s2` = 0: return to IDLE. No outputs change.
  - PRESS_WAIT, `s2` = 1 with `dcnt` = `DEBOUNCE_CYCLES`−1: go to HELD and pulse `btn_press`. Otherwise increment `dcnt`.
  - HELD, `s2` = 0: go to REL_WAIT with `dcnt` = 1.
  - REL_WAIT, `s2` = 1: return to HELD. No pulse is generated.
  - REL_WAIT, `s2` = 0 with `dcnt` = `DEBOUNCE_CYCLES`−1: go to IDLE and pulse `btn_release`. Otherwise increment `dcnt`.
- `btn_level` is a registered output: 1 in HELD and REL_WAIT, 0 in IDLE and PRESS_WAIT.
- Long press:
  - `lcnt` clears on entry to HELD from PRESS_WAIT.
  - It increments every cycle spent in HELD or REL_WAIT, saturating.
  - `btn_long` pulses on the cycle `lcnt` reaches `LONG_CYCLES`, in either state, and only once per accepted press.
  - A release bounce (HELD → REL_WAIT → HELD) neither restarts nor re-arms `lcnt`.
- `press_count` increments on the same edge that asserts `btn_press` and wraps from 255 to 0. It is not affected by release or long-press events.
- Pulse ordering: `btn_press`, `btn_release` and `btn_long` are never asserted in the same cycle. `btn_long` cannot fire after `btn_release`.
- Reset:
  - All outputs reset to 0: `btn_level`, `btn_press`, `btn_release`, `btn_long`, and `press_count` = 0x00.
  - State goes to IDLE and both counters clear, asynchronously, including mid-qualification or mid-hold.
  - If the button is held through reset deassertion, it is treated as a new press and qualified normally.

## Timing
- All outputs are registered, with no combinational path from `button`.
- Press latency: call the first edge that samples `button` = 1 edge 1. Then `s2` = 1 after edge 2, and `btn_level`, `btn_press` and `press_count` update after edge `DEBOUNCE_CYCLES`+2. This holds if `button` stays high throughout.
- Release latency: symmetric. `btn_level` = 0 and `btn_release` assert after edge `DEBOUNCE_CYCLES`+2, counted from the first edge sampling 0.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles causes zero output activity.
- `btn_long` asserts exactly `LONG_CYCLES` cycles after the `btn_press` cycle.
- Every pulse output is high for exactly one cycle.

## Test plan
Benches run with `DEBOUNCE_CYCLES` = 4 and `LONG_CYCLES` = 20.
- Clean press: `button` 0→1 held for 10 cycles → `btn_press` is a single pulse after edge 6, `btn_level` = 1 from edge 6, `press_count` 0→1.
- Bounce reject: pulses of 1, 2 and 3 cycles separated by 2 low cycles, then low → `btn_level` stays 0, no pulses, `press_count` stays 0.
- Release with bounce: held press, then 0 for 2 cycles, 1 for 1 cycle, then 0 steady → exactly one `btn_release`, 6 edges after the last rising-to-0 sample edge. `btn_level` stays 1 until then, with no extra `btn_press`.
- Long press: hold for 40 cycles → one `btn_long` exactly 20 cycles after `btn_press`, none later. A subsequent hold of 10 cycles → no `btn_long`.
- Wrap: 256 clean presses → `press_count` returns to 0x00, with exactly 256 `btn_press` pulses.
- Reset mid-hold: assert `rst_n` = 0 in HELD while `button` = 1 → all outputs 0 immediately. Release reset with the button still high → `btn_press` 6 edges later and `press_count` = 1.

Source files
------------

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Synchronizes and debounces a raw push button; emits a clean
//            level, press/release/long-press pulses and an 8-bit press tally.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       btn_long,
    output logic [7:0] press_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] c_dcnt_one  = DW'(1);
    localparam logic [DW-1:0] c_dcnt_last = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] c_lcnt_sat  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] c_lcnt_fire = LW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_s1;
    logic          r_s2;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_nxt;
    logic [LW-1:0] r_lcnt;
    logic [LW-1:0] w_lcnt_nxt;
    logic          w_press;
    logic          w_release;
    logic          w_long;
    logic          w_pressed_state;

    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic [7:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= button;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = '0;
        w_press     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_s2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_dcnt_nxt  = c_dcnt_one;
                end
            end
            PRESS_WAIT: begin
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                end else if (r_dcnt == c_dcnt_last) begin
                    w_state_nxt = HELD;
                    w_press     = 1'b1;
                end else begin
                    w_dcnt_nxt  = r_dcnt + c_dcnt_one;
                end
            end
            HELD: begin
                if (!r_s2) begin
                    w_state_nxt = REL_WAIT;
                    w_dcnt_nxt  = c_dcnt_one;
                end
            end
            REL_WAIT: begin
                if (r_s2) begin
                    w_state_nxt = HELD;
                end else if (r_dcnt == c_dcnt_last) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else begin
                    w_dcnt_nxt  = r_dcnt + c_dcnt_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Long-press timer keeps running through release bounce; the release
    // edge itself suppresses the pulse so it can never follow btn_release.
    assign w_pressed_state = (r_state == HELD) || (r_state == REL_WAIT);

    always_comb begin
        w_lcnt_nxt = r_lcnt;
        w_long     = 1'b0;
        if (w_press) begin
            w_lcnt_nxt = '0;
        end else if (w_pressed_state) begin
            if (r_lcnt != c_lcnt_sat) begin
                w_lcnt_nxt = r_lcnt + LW'(1);
            end
            w_long = (r_lcnt == c_lcnt_fire) && !w_release;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_count   <= 8'h00;
        end else begin
            r_level   <= (w_state_nxt == HELD) || (w_state_nxt == REL_WAIT);
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            if (w_press) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_long    = r_long;
    assign press_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Directed and randomized checks of button_debouncer against an
//            edge-level behavioural model of debounce acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int D = 4;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic       btn_long;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    // Model: level flips after D consecutive synchronized samples that differ from it
    bit       m_s1, m_s2, m_level;
    int       m_run;
    int       cyc;
    int       m_press_at;
    bit       m_rel_since;
    bit       e_press, e_rel, e_long;
    logic [7:0] m_count;
    int       n_press;
    int       n_long;

    button_debouncer #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0;
        m_count = 8'h00; m_press_at = -1; m_rel_since = 1'b0;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    endtask

    task automatic model_edge(input bit b);
        bit seen;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        cyc++;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        if (seen != m_level) m_run++;
        else m_run = 0;
        if (m_run == D) begin
            m_run = 0;
            m_level = !m_level;
            if (m_level) begin
                e_press = 1'b1;
                m_count = m_count + 8'd1;
                m_press_at = cyc;
                m_rel_since = 1'b0;
            end else begin
                e_rel = 1'b1;
                m_rel_since = 1'b1;
            end
        end
        if (m_press_at >= 0 && cyc == m_press_at + L && !m_rel_since) e_long = 1'b1;
    endtask

    task automatic step(input bit b);
        button = b;
        @(posedge clk);
        #1;
        model_edge(b);
        check("level",   {7'd0, btn_level},   {7'd0, m_level});
        check("press",   {7'd0, btn_press},   {7'd0, e_press});
        check("release", {7'd0, btn_release}, {7'd0, e_rel});
        check("long",    {7'd0, btn_long},    {7'd0, e_long});
        check("count",   press_count,         m_count);
        if (btn_press) n_press++;
        if (btn_long)  n_long++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   {7'd0, btn_level},   8'd0);
        check({tag, "_press"},   {7'd0, btn_press},   8'd0);
        check({tag, "_release"}, {7'd0, btn_release}, 8'd0);
        check({tag, "_long"},    {7'd0, btn_long},    8'd0);
        check({tag, "_count"},   press_count,         8'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int np0;
        int nl0;
        cyc = 0; n_press = 0; n_long = 0;
        button = 1'b0;
        rst_n  = 1'b1;
        #2;
        do_reset();

        // Clean press: pulse lands on edge 6
        for (int i = 1; i <= 10; i++) begin
            step(1'b1);
            if (i == 6) check("clean_press_edge6", {7'd0, btn_press}, 8'd1);
        end
        check("clean_count", press_count, 8'd1);

        // Release with bounce: 0,0,1 then steady 0
        step(1'b0); step(1'b0); step(1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0);
            if (i == 6) check("bounce_release_edge6", {7'd0, btn_release}, 8'd1);
        end
        check("bounce_release_level", {7'd0, btn_level}, 8'd0);

        // Bounce reject: 1, 2 and 3 cycle glitches
        np0 = n_press;
        for (int w = 1; w <= 3; w++) begin
            for (int k = 0; k < w; k++) step(1'b1);
            step(1'b0); step(1'b0);
        end
        repeat (6) step(1'b0);
        check("glitch_no_press", 8'(n_press - np0), 8'd0);
        check("glitch_count", press_count, 8'd1);

        // Long press then short press
        nl0 = n_long;
        repeat (40) step(1'b1);
        repeat (8) step(1'b0);
        check("long_once", 8'(n_long - nl0), 8'd1);
        repeat (10) step(1'b1);
        repeat (8) step(1'b0);
        check("short_no_long", 8'(n_long - nl0), 8'd1);

        // Reset mid-hold, button still high through deassertion
        repeat (8) step(1'b1);
        check("held_level", {7'd0, btn_level}, 8'd1);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1);
            if (i == 6) begin
                check("rst_press_edge6", {7'd0, btn_press}, 8'd1);
                check("rst_press_count", press_count, 8'd1);
            end
        end
        repeat (8) step(1'b0);

        // Wrap: 256 clean presses from a fresh reset
        do_reset();
        np0 = n_press;
        for (int p = 0; p < 256; p++) begin
            repeat (7) step(1'b1);
            repeat (7) step(1'b0);
        end
        check("wrap_count", press_count, 8'h00);
        check("wrap_pulses", 8'((n_press - np0) == 256), 8'd1);

        // Randomized runs of random lengths, occasionally long holds
        for (int r = 0; r < 400; r++) begin
            bit v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 30))
                                               : int'($urandom_range(1, 7));
            repeat (len) step(v);
        end
        repeat (10) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
